// File: rtl/alu_serial_rx.sv
// Serial frame receiver for the ALU input port.
// Deserializes 11-bit packets from sin: start(0), type, d[7:0], stop(1).
// Eight DATA packets build {B, A}. The CTL packet then carries the opcode and
// a 4-bit CRC (x^4+x+1) taken over {B, A, 1'b1, op}. One decoded command
// with priority-resolved error flags is presented per frame.
module alu_serial_rx #(
  parameter int         DATA_PKTS = 8,
  parameter logic [3:0] CRC_INIT  = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        cmd_valid,
  output logic [31:0] cmd_A,
  output logic [31:0] cmd_B,
  output logic [2:0]  cmd_op,
  output logic [2:0]  cmd_err,
  output logic        busy
);

  localparam int CW = $clog2(DATA_PKTS + 1);
  localparam int AW = 8 * DATA_PKTS;

  typedef enum logic [2:0] {
    IDLE,
    TYPE,
    BITS,
    STOP,
    RESYNC,
    DONE
  } state_t;

  state_t          state;
  logic            is_ctl;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [CW-1:0]   count;
  logic            ovf;
  logic [3:0]      crc;
  logic [AW-1:0]   data_asm;  // first packet ends up in the top byte (B[31:24])

  logic [2:0]      ctl_op;
  logic [3:0]      ctl_crc_rx;
  logic [3:0]      ctl_crc_calc;
  logic [2:0]      ctl_err;

  // One serial step of the x^4+x+1 LFSR.
  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2:0], 1'b0} ^ {2'b00, fb, fb};
  endfunction

  // Feed one byte into the CRC, MSB first.
  function automatic logic [3:0] crc_byte(input logic [3:0] c, input logic [7:0] d);
    logic [3:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = crc_step(r, d[i]);
    return r;
  endfunction

  // Decode the CTL byte held in shreg: finish the CRC with {1'b1, op} and resolve errors.
  always_comb begin
    ctl_op       = shreg[6:4];
    ctl_crc_rx   = shreg[3:0];
    ctl_crc_calc = crc_step(crc, 1'b1);
    ctl_crc_calc = crc_step(ctl_crc_calc, ctl_op[2]);
    ctl_crc_calc = crc_step(ctl_crc_calc, ctl_op[1]);
    ctl_crc_calc = crc_step(ctl_crc_calc, ctl_op[0]);
    ctl_err      = 3'b000;
    if (count != CW'(DATA_PKTS) || ovf)
      ctl_err = 3'b100;
    else if (ctl_crc_rx != ctl_crc_calc)
      ctl_err = 3'b010;
    else if (!(ctl_op inside {3'b000, 3'b001, 3'b100, 3'b101}))
      ctl_err = 3'b001;
  end

  // Packet FSM, frame assembly, CRC accumulation and registered command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here, including the assembly buffer, is reset so a
    // frame interrupted by reset can never leak bytes or CRC into the next one.
    if (!rst_n) begin
      state     <= IDLE;
      is_ctl    <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      crc       <= CRC_INIT;
      data_asm  <= '0;
      cmd_valid <= 1'b0;
      cmd_A     <= '0;
      cmd_B     <= '0;
      cmd_op    <= '0;
      cmd_err   <= '0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read below sees
      // the value from before this clock edge.
      cmd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!sin) begin
            busy  <= 1'b1;
            state <= TYPE;
          end
        end
        TYPE: begin
          is_ctl  <= sin;
          bit_cnt <= '0;
          state   <= BITS;
        end
        BITS: begin
          shreg   <= {shreg[6:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= STOP;
        end
        STOP: begin
          if (!sin) begin
            // Framing error: drop the whole frame and wait for the line to idle.
            count <= '0;
            ovf   <= 1'b0;
            crc   <= CRC_INIT;
            busy  <= 1'b0;
            state <= RESYNC;
          end else if (!is_ctl) begin
            if (count < CW'(DATA_PKTS)) begin
              data_asm <= {data_asm[AW-9:0], shreg};
              crc      <= crc_byte(crc, shreg);
              count    <= count + CW'(1);
            end else begin
              ovf <= 1'b1;
            end
            state <= IDLE;
          end else begin
            cmd_valid <= 1'b1;
            cmd_op    <= ctl_op;
            cmd_err   <= ctl_err;
            if (!ctl_err[2]) begin
              cmd_B <= data_asm[63:32];
              cmd_A <= data_asm[31:0];
            end
            busy  <= 1'b0;
            count <= '0;
            ovf   <= 1'b0;
            crc   <= CRC_INIT;
            state <= DONE;
          end
        end
        RESYNC: begin
          if (sin) state <= IDLE;
        end
        DONE: begin
          // A start bit may already arrive in this cycle.
          if (!sin) begin
            busy  <= 1'b1;
            state <= TYPE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed bench for alu_serial_rx: drives frames bit by bit and checks the
// decoded command, error flags, pulse latency/width and busy.
module tb_alu_serial_rx;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic        cmd_valid;
  logic [31:0] cmd_A;
  logic [31:0] cmd_B;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int exp_pulses = 0;

  alu_serial_rx #(.DATA_PKTS(8), .CRC_INIT(4'b0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .cmd_valid (cmd_valid),
    .cmd_A     (cmd_A),
    .cmd_B     (cmd_B),
    .cmd_op    (cmd_op),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count high cycles of cmd_valid; a stretched pulse shows up as extra counts.
  always @(negedge clk) if (cmd_valid) pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC over {B, A, 1'b1, op}, x^4+x+1, MSB first, init 0.
  function automatic logic [3:0] crc_of(input logic [31:0] b, input logic [31:0] a,
                                        input logic [2:0] op);
    logic [67:0] msg;
    logic [3:0]  c;
    logic        fb;
    msg = {b, a, 1'b1, op};
    c   = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // Drive one bit for one clock; return 1 ns after the sampling edge.
  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_packet(input logic ctl, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(ctl);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
  endtask

  // ndata DATA packets from {b, a, 8'hAA} then a CTL packet; returns right after the CTL stop edge.
  task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                            input logic [3:0] crc, input int ndata);
    logic [71:0] d;
    d = {b, a, 8'hAA};
    for (int k = 0; k < ndata; k++) send_packet(1'b0, d[71-8*k -: 8], 1'b1);
    send_packet(1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  task automatic expect_cmd(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input logic [2:0] err);
    exp_pulses++;
    check({tag, ".valid"}, cmd_valid, 1'b1);
    check({tag, ".A"}, cmd_A, a);
    check({tag, ".B"}, cmd_B, b);
    check({tag, ".op"}, cmd_op, op);
    check({tag, ".err"}, cmd_err, err);
    check({tag, ".busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    sin   = 1'b1;
    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.valid", cmd_valid, 1'b0);
    check("rst.A", cmd_A, 32'h0);
    check("rst.B", cmd_B, 32'h0);
    check("rst.op", cmd_op, 3'b000);
    check("rst.err", cmd_err, 3'b000);
    check("rst.busy", busy, 1'b0);
    idle(2);

    // 1: clean AND frame.
    send_frame(32'h2, 32'h1, 3'b000, crc_of(32'h2, 32'h1, 3'b000), 8);
    expect_cmd("t1", 32'h1, 32'h2, 3'b000, 3'b000);
    idle(1);
    check("t1.pulse_end", cmd_valid, 1'b0);
    idle(2);

    // 2: bad CRC, then corrupted A with the original CRC.
    send_frame(32'h2, 32'h1, 3'b000, crc_of(32'h2, 32'h1, 3'b000) ^ 4'b0001, 8);
    expect_cmd("t2a", 32'h1, 32'h2, 3'b000, 3'b010);
    idle(3);
    send_frame(32'h2, 32'h21, 3'b100, crc_of(32'h2, 32'h1, 3'b100), 8);
    expect_cmd("t2b", 32'h21, 32'h2, 3'b100, 3'b010);
    idle(3);

    // 3: unsupported opcode with a correct CRC.
    send_frame(32'h9ABCDEF0, 32'h12345678, 3'b010, crc_of(32'h9ABCDEF0, 32'h12345678, 3'b010), 8);
    expect_cmd("t3", 32'h12345678, 32'h9ABCDEF0, 3'b010, 3'b001);
    idle(3);

    // 4: short frame, long frame, empty frame, then a clean ADD.
    send_frame(32'h11111111, 32'h0, 3'b100, 4'h0, 2);
    expect_cmd("t4short", 32'h12345678, 32'h9ABCDEF0, 3'b100, 3'b100);
    idle(3);
    send_frame(32'h22222222, 32'h33333333, 3'b001, crc_of(32'h22222222, 32'h33333333, 3'b001), 9);
    expect_cmd("t4long", 32'h12345678, 32'h9ABCDEF0, 3'b001, 3'b100);
    idle(3);
    send_frame(32'h0, 32'h0, 3'b000, 4'h0, 0);
    expect_cmd("t4empty", 32'h12345678, 32'h9ABCDEF0, 3'b000, 3'b100);
    idle(3);
    send_frame(32'h7, 32'h5, 3'b100, crc_of(32'h7, 32'h5, 3'b100), 8);
    expect_cmd("t4ok", 32'h5, 32'h7, 3'b100, 3'b000);
    idle(3);

    // 5: framing error in packet 3, line held low, then a clean SUB.
    send_packet(1'b0, 8'hDE, 1'b1);
    send_packet(1'b0, 8'hAD, 1'b1);
    send_packet(1'b0, 8'hBE, 1'b1);
    send_packet(1'b0, 8'hEF, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    check("t5.busy_cleared", busy, 1'b0);
    idle(2);
    check("t5.no_pulse", pulses, exp_pulses);
    send_frame(32'h1, 32'hFFFFFFFF, 3'b101, crc_of(32'h1, 32'hFFFFFFFF, 3'b101), 8);
    expect_cmd("t5", 32'hFFFFFFFF, 32'h1, 3'b101, 3'b000);
    idle(3);

    // 6: asynchronous reset in the middle of BITS.
    send_packet(1'b0, 8'h55, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    check("t6.busy_mid", busy, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("t6.rst_A", cmd_A, 32'h0);
    check("t6.rst_B", cmd_B, 32'h0);
    check("t6.rst_op", cmd_op, 3'b000);
    check("t6.rst_busy", busy, 1'b0);
    check("t6.rst_valid", cmd_valid, 1'b0);
    #2 rst_n = 1'b1;
    idle(12);
    check("t6.no_pulse", pulses, exp_pulses);

    // 6b: two frames with no gap; the second start bit lands in DONE.
    send_frame(32'hF0F0F0F0, 32'h0F0F0F0F, 3'b001, crc_of(32'hF0F0F0F0, 32'h0F0F0F0F, 3'b001), 8);
    expect_cmd("t6f1", 32'h0F0F0F0F, 32'hF0F0F0F0, 3'b001, 3'b000);
    send_frame(32'h3, 32'h4, 3'b100, crc_of(32'h3, 32'h4, 3'b100), 8);
    expect_cmd("t6f2", 32'h4, 32'h3, 3'b100, 3'b000);
    idle(1);
    check("t6.pulse_end", cmd_valid, 1'b0);
    idle(2);
    check("total_pulses", pulses, exp_pulses);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
